// File: rtl/hls_deadlock_pkg.sv
// Shared definitions for the HLS deadlock-monitor blocks: default sizing,
// the stall report record and the report FSM state encoding.
package hls_deadlock_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_THRESHOLD = 1024;

    // Widest legal channel index (32 channels) and counter (32 bits).
    typedef struct packed {
        logic [4:0]  ch;
        logic [31:0] cycles;
    } report_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } report_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hls_axis_stall_counter.sv
// One AXIS channel: stall decode, saturating consecutive-stall counter,
// registered over-threshold block bit and its rising-edge pulse.
module hls_axis_stall_counter
    import hls_deadlock_pkg::*;
#(
    parameter int   CNT_W     = DEF_CNT_W,
    parameter int   THRESHOLD = DEF_THRESHOLD,
    parameter logic IS_OUTPUT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             tvalid,
    input  logic             tready,
    output logic             block,
    output logic             rise,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

    logic             stall;
    logic [CNT_W-1:0] count;
    logic             block_next;

    // A master stalls waiting for ready; a slave stalls waiting for data.
    assign stall = IS_OUTPUT ? (tvalid & ~tready) : (tready & ~tvalid);

    always_comb begin
        count_next = '0;
        if (enable && stall) begin
            count_next = (count == '1) ? count : count + CNT_W'(1);
        end
    end

    assign block_next = (count_next >= THR);
    assign rise       = block_next & ~block;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            block <= 1'b0;
        end else begin
            count <= count_next;
            block <= block_next;
        end
    end

endmodule

// File: rtl/hls_axis_stall_detector.sv
// Per-channel AXIS stall detection with a serialized stall report stream;
// rising block bits queue in a pending mask drained lowest index first.
module hls_axis_stall_detector
    import hls_deadlock_pkg::*;
#(
    parameter int                NUM_CH       = DEF_NUM_CH,
    parameter int                CNT_W        = DEF_CNT_W,
    parameter int                THRESHOLD    = DEF_THRESHOLD,
    parameter logic [NUM_CH-1:0] CH_IS_OUTPUT = NUM_CH'(2'b10),
    localparam int               CH_W         = ch_width(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] axis_tvalid,
    input  logic [NUM_CH-1:0] axis_tready,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              report_valid,
    input  logic              report_ready,
    output logic [CH_W-1:0]   report_ch,
    output logic [CNT_W-1:0]  report_cycles
);

    // Handshake: a report transfers on an edge where report_valid and
    // report_ready are both 1; report_ch/report_cycles hold until then.

    logic [NUM_CH-1:0] rise;
    logic [CNT_W-1:0]  count_next [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] clear_mask;
    logic              pick_found;
    logic [CH_W-1:0]   pick_idx;
    report_state_e     state;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hls_axis_stall_counter #(
            .CNT_W     (CNT_W),
            .THRESHOLD (THRESHOLD),
            .IS_OUTPUT (CH_IS_OUTPUT[i])
        ) u_counter (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable),
            .tvalid     (axis_tvalid[i]),
            .tready     (axis_tready[i]),
            .block      (axis_block_sigs[i]),
            .rise       (rise[i]),
            .count_next (count_next[i])
        );
    end

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_found = 1'b1;
                pick_idx   = CH_W'(i);
            end
        end
    end

    assign clear_mask   = (state == IDLE && pick_found) ? (NUM_CH'(1) << pick_idx) : '0;
    assign report_valid = (state == SEND);

    // Rise is OR-ed after the clear so a channel re-blocking while its own
    // report is being issued queues a fresh report.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            pending       <= '0;
            report_ch     <= '0;
            report_cycles <= '0;
        end else begin
            pending <= (pending & ~clear_mask) | rise;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        report_ch     <= pick_idx;
                        report_cycles <= count_next[pick_idx];
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (report_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_axis_stall_detector.sv
// Directed bench for hls_axis_stall_detector: a THRESHOLD=4 instance for the
// report/priority paths and a CNT_W=4, THRESHOLD=15 instance for saturation.
module tb_hls_axis_stall_detector;

    logic       clock = 1'b0;
    logic       reset;

    logic       a_enable;
    logic [1:0] a_tvalid, a_tready, a_block;
    logic       a_rep_valid, a_rep_ready;
    logic [0:0] a_rep_ch;
    logic [15:0] a_rep_cycles;

    logic       b_enable;
    logic [1:0] b_tvalid, b_tready, b_block;
    logic       b_rep_valid, b_rep_ready;
    logic [0:0] b_rep_ch;
    logic [3:0] b_rep_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    hls_axis_stall_detector #(
        .NUM_CH(2), .CNT_W(16), .THRESHOLD(4), .CH_IS_OUTPUT(2'b10)
    ) dut_a (
        .clock           (clock),
        .reset           (reset),
        .enable          (a_enable),
        .axis_tvalid     (a_tvalid),
        .axis_tready     (a_tready),
        .axis_block_sigs (a_block),
        .report_valid    (a_rep_valid),
        .report_ready    (a_rep_ready),
        .report_ch       (a_rep_ch),
        .report_cycles   (a_rep_cycles)
    );

    hls_axis_stall_detector #(
        .NUM_CH(2), .CNT_W(4), .THRESHOLD(15), .CH_IS_OUTPUT(2'b10)
    ) dut_b (
        .clock           (clock),
        .reset           (reset),
        .enable          (b_enable),
        .axis_tvalid     (b_tvalid),
        .axis_tready     (b_tready),
        .axis_block_sigs (b_block),
        .report_valid    (b_rep_valid),
        .report_ready    (b_rep_ready),
        .report_ch       (b_rep_ch),
        .report_cycles   (b_rep_cycles)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_report(input string tag, input logic [31:0] ch, input logic [31:0] cyc);
        chk({tag, "_valid"}, 32'(a_rep_valid), 32'd1);
        chk({tag, "_ch"}, 32'(a_rep_ch), ch);
        chk({tag, "_cycles"}, 32'(a_rep_cycles), cyc);
    endtask

    initial begin
        reset       = 1'b1;
        a_enable    = 1'b1;
        a_tvalid    = 2'b00;
        a_tready    = 2'b00;
        a_rep_ready = 1'b0;
        b_enable    = 1'b1;
        b_tvalid    = 2'b00;
        b_tready    = 2'b00;
        b_rep_ready = 1'b0;
        tick(2);
        chk("rst_block", 32'(a_block), 32'd0);
        chk("rst_valid", 32'(a_rep_valid), 32'd0);
        chk("rst_ch", 32'(a_rep_ch), 32'd0);
        chk("rst_cycles", 32'(a_rep_cycles), 32'd0);
        chk("rst_b_block", 32'(b_block), 32'd0);
        reset = 1'b0;

        // Output channel 1 stalls; block rises at edge 4, report {1,5} after edge 5.
        a_tvalid = 2'b10; a_tready = 2'b00; a_rep_ready = 1'b1;
        tick(3);
        chk("t1_block_e3", 32'(a_block), 32'd0);
        tick(1);
        chk("t1_block_e4", 32'(a_block), 32'b10);
        chk("t1_valid_e4", 32'(a_rep_valid), 32'd0);
        tick(1);
        chk_a_report("t1_rep_e5", 32'd1, 32'd5);
        tick(1);
        chk("t1_valid_e6", 32'(a_rep_valid), 32'd0);
        chk("t1_block_e6", 32'(a_block), 32'b10);
        a_tready = 2'b10;
        tick(1);
        chk("t1_block_clear", 32'(a_block), 32'd0);
        chk("t1_valid_e7", 32'(a_rep_valid), 32'd0);
        a_tvalid = 2'b00; a_tready = 2'b00;
        tick(1);
        chk("t1_valid_e8", 32'(a_rep_valid), 32'd0);

        // Input channel 0: 3 stalls, a handshake, 3 stalls -> never blocks.
        a_tready = 2'b01; a_tvalid = 2'b00;
        for (int i = 0; i < 7; i++) begin
            a_tvalid = (i == 3) ? 2'b01 : 2'b00;
            tick(1);
            chk("t2_block", 32'(a_block), 32'd0);
            chk("t2_valid", 32'(a_rep_valid), 32'd0);
        end
        a_tvalid = 2'b00; a_tready = 2'b00;
        tick(2);
        chk("t2_valid_after", 32'(a_rep_valid), 32'd0);

        // Both channels cross on the same edge: ch0, idle cycle, ch1.
        a_tready = 2'b01; a_tvalid = 2'b10; a_rep_ready = 1'b1;
        tick(3);
        chk("t3_block_e3", 32'(a_block), 32'd0);
        tick(1);
        chk("t3_block_e4", 32'(a_block), 32'b11);
        chk("t3_valid_e4", 32'(a_rep_valid), 32'd0);
        tick(1);
        chk_a_report("t3_rep0", 32'd0, 32'd5);
        tick(1);
        chk("t3_gap", 32'(a_rep_valid), 32'd0);
        tick(1);
        chk_a_report("t3_rep1", 32'd1, 32'd7);
        tick(1);
        chk("t3_valid_e8", 32'(a_rep_valid), 32'd0);
        tick(1);
        chk("t3_pending_empty", 32'(a_rep_valid), 32'd0);
        a_tready = 2'b00; a_tvalid = 2'b00;
        tick(1);
        chk("t3_block_clear", 32'(a_block), 32'd0);

        // Report held 20 cycles with ready low; ch0 rise waits in pending.
        a_rep_ready = 1'b0; a_tvalid = 2'b10; a_tready = 2'b00;
        tick(4);
        chk("t4_block_e4", 32'(a_block), 32'b10);
        tick(1);
        chk_a_report("t4_hold_e5", 32'd1, 32'd5);
        a_tready = 2'b01;
        for (int i = 0; i < 19; i++) begin
            tick(1);
            chk_a_report("t4_hold", 32'd1, 32'd5);
        end
        chk("t4_block_both", 32'(a_block), 32'b11);
        a_rep_ready = 1'b1;
        tick(1);
        chk("t4_accept", 32'(a_rep_valid), 32'd0);
        tick(1);
        chk_a_report("t4_rep_ch0", 32'd0, 32'd21);
        tick(1);
        chk("t4_valid_done", 32'(a_rep_valid), 32'd0);
        a_tvalid = 2'b00; a_tready = 2'b00;
        tick(1);
        chk("t4_block_clear", 32'(a_block), 32'd0);
        chk("t4_valid_idle", 32'(a_rep_valid), 32'd0);

        // Narrow counter saturates at 15 and block holds; enable low clears it.
        b_tvalid = 2'b10; b_tready = 2'b00; b_rep_ready = 1'b0;
        tick(14);
        chk("t5_block_e14", 32'(b_block), 32'd0);
        tick(1);
        chk("t5_block_e15", 32'(b_block), 32'b10);
        tick(1);
        chk("t5_valid_e16", 32'(b_rep_valid), 32'd1);
        chk("t5_ch_e16", 32'(b_rep_ch), 32'd1);
        chk("t5_cycles_e16", 32'(b_rep_cycles), 32'd15);
        tick(24);
        chk("t5_block_e40", 32'(b_block), 32'b10);
        chk("t5_cycles_e40", 32'(b_rep_cycles), 32'd15);
        b_enable = 1'b0;
        tick(1);
        chk("t5_block_disable", 32'(b_block), 32'd0);
        b_tvalid = 2'b00;
        b_enable = 1'b1;

        // Reset mid-report with both channels blocked drops everything.
        a_rep_ready = 1'b0; a_tvalid = 2'b10; a_tready = 2'b01;
        tick(4);
        chk("t6_block_e4", 32'(a_block), 32'b11);
        tick(1);
        chk_a_report("t6_rep_e5", 32'd0, 32'd5);
        reset = 1'b1;
        tick(1);
        chk("t6_rst_block", 32'(a_block), 32'd0);
        chk("t6_rst_valid", 32'(a_rep_valid), 32'd0);
        chk("t6_rst_ch", 32'(a_rep_ch), 32'd0);
        chk("t6_rst_cycles", 32'(a_rep_cycles), 32'd0);
        chk("t6_rst_b_valid", 32'(b_rep_valid), 32'd0);
        reset = 1'b0; a_tvalid = 2'b00; a_tready = 2'b00; a_rep_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t6_no_report", 32'(a_rep_valid), 32'd0);
            chk("t6_block_low", 32'(a_block), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
